muldiv_ctrl: RTL and testbench

Sequencing controller for the shared iterative multiplier and divider in the CPU datapath. It accepts MULT/DIV/MTHI/MTLO operations from the control unit and launches the selected unit with a one-cycle start pulse. It waits for the unit's done, then commits the 64-bit result into the architectural HI/LO registers. It holds `busy` high so the pipeline stalls for the whole operation.

---
 rtl/muldiv_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequences the shared iterative multiplier/divider and commits results into HI/LO.
// Latency: MTHI/MTLO 1 edge; MULT/DIV 2 + unit latency + 1 edges; watchdog aborts after TIMEOUT_CYCLES WAIT cycles.
// Backpressure: op_ready is high only in IDLE; requester holds op_valid until accepted. Optional MULDIV_DIVZERO_TRAP_EN.
module muldiv_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [1:0]  op_code,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        op_ready,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        mul_start,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic        mul_done,
  input  logic [63:0] mul_result,
  output logic        div_start,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  input  logic        div_done,
  input  logic [31:0] div_quot,
  input  logic [31:0] div_rem,
  output logic        div_zero,
  output logic        timeout_err
);

  localparam logic [1:0] OP_MULT = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;
  localparam logic [1:0] OP_MTHI = 2'b10;
  localparam logic [1:0] OP_MTLO = 2'b11;

  localparam int unsigned CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_M_START,
    S_M_WAIT,
    S_D_START,
    S_D_WAIT
  } state_t;

  state_t        state_q;
  logic          op_ready_q;
  logic          busy_q;
  logic [31:0]   hi_q;
  logic [31:0]   lo_q;
  logic          mul_start_q;
  logic [31:0]   mul_a_q;
  logic [31:0]   mul_b_q;
  logic          div_start_q;
  logic [31:0]   div_a_q;
  logic [31:0]   div_b_q;
  logic          timeout_err_q;
  logic [CW-1:0] wdog_q;
  logic [CW-1:0] wdog_d;
  logic          wdog_expired;
`ifdef MULDIV_DIVZERO_TRAP_EN
  logic          div_zero_q;
`endif

  // Watchdog next count and expiry: the current WAIT cycle is the last one allowed.
  always_comb begin
    wdog_d       = wdog_q + CW'(1);
    wdog_expired = (wdog_q == CW'(TIMEOUT_CYCLES - 1));
  end

  // Sequencer FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      op_ready_q    <= 1'b1;
      busy_q        <= 1'b0;
      hi_q          <= '0;
      lo_q          <= '0;
      mul_start_q   <= 1'b0;
      mul_a_q       <= '0;
      mul_b_q       <= '0;
      div_start_q   <= 1'b0;
      div_a_q       <= '0;
      div_b_q       <= '0;
      timeout_err_q <= 1'b0;
      wdog_q        <= '0;
`ifdef MULDIV_DIVZERO_TRAP_EN
      div_zero_q    <= 1'b0;
`endif
    end else begin
      // Pulses default low so each lasts exactly one cycle.
      mul_start_q <= 1'b0;
      div_start_q <= 1'b0;
`ifdef MULDIV_DIVZERO_TRAP_EN
      div_zero_q  <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (op_valid) begin
            case (op_code)
              OP_MULT: begin
                mul_a_q     <= op_a;
                mul_b_q     <= op_b;
                mul_start_q <= 1'b1;
                state_q     <= S_M_START;
                op_ready_q  <= 1'b0;
                busy_q      <= 1'b1;
              end
              OP_DIV: begin
                div_a_q <= op_a;
                div_b_q <= op_b;
`ifdef MULDIV_DIVZERO_TRAP_EN
                if (op_b == '0) begin
                  // Trap instead of launching; HI/LO keep their values.
                  div_zero_q <= 1'b1;
                end else begin
                  div_start_q <= 1'b1;
                  state_q     <= S_D_START;
                  op_ready_q  <= 1'b0;
                  busy_q      <= 1'b1;
                end
`else
                div_start_q <= 1'b1;
                state_q     <= S_D_START;
                op_ready_q  <= 1'b0;
                busy_q      <= 1'b1;
`endif
              end
              OP_MTHI: hi_q <= op_a;
              OP_MTLO: lo_q <= op_a;
              default: ;
            endcase
          end
        end
        S_M_START: begin
          wdog_q  <= '0;
          state_q <= S_M_WAIT;
        end
        S_D_START: begin
          wdog_q  <= '0;
          state_q <= S_D_WAIT;
        end
        S_M_WAIT: begin
          if (mul_done) begin
            lo_q       <= mul_result[31:0];
            hi_q       <= mul_result[63:32];
            state_q    <= S_IDLE;
            op_ready_q <= 1'b1;
            busy_q     <= 1'b0;
          end else if (wdog_expired) begin
            timeout_err_q <= 1'b1;
            state_q       <= S_IDLE;
            op_ready_q    <= 1'b1;
            busy_q        <= 1'b0;
          end else begin
            wdog_q <= wdog_d;
          end
        end
        S_D_WAIT: begin
          if (div_done) begin
            lo_q       <= div_quot;
            hi_q       <= div_rem;
            state_q    <= S_IDLE;
            op_ready_q <= 1'b1;
            busy_q     <= 1'b0;
          end else if (wdog_expired) begin
            timeout_err_q <= 1'b1;
            state_q       <= S_IDLE;
            op_ready_q    <= 1'b1;
            busy_q        <= 1'b0;
          end else begin
            wdog_q <= wdog_d;
          end
        end
        default: begin
          state_q    <= S_IDLE;
          op_ready_q <= 1'b1;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign op_ready    = op_ready_q;
  assign busy        = busy_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign mul_start   = mul_start_q;
  assign mul_a       = mul_a_q;
  assign mul_b       = mul_b_q;
  assign div_start   = div_start_q;
  assign div_a       = div_a_q;
  assign div_b       = div_b_q;
  assign timeout_err = timeout_err_q;
`ifdef MULDIV_DIVZERO_TRAP_EN
  assign div_zero    = div_zero_q;
`else
  assign div_zero    = 1'b0;
`endif

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl with behavioural multiplier/divider models.
// Stimulus pushes expected HI/LO/flags per op; a negedge monitor pops on each op completion.
module tb_muldiv_ctrl;
  localparam int TMO = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic [1:0]  op_code;
  logic [31:0] op_a, op_b;
  logic        op_ready, busy;
  logic [31:0] hi, lo;
  logic        mul_start, mul_done;
  logic [31:0] mul_a, mul_b;
  logic [63:0] mul_result;
  logic        div_start, div_done;
  logic [31:0] div_a, div_b, div_quot, div_rem;
  logic        div_zero, timeout_err;

  muldiv_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_code(op_code),
    .op_a(op_a), .op_b(op_b), .op_ready(op_ready), .busy(busy),
    .hi(hi), .lo(lo), .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_done(mul_done), .mul_result(mul_result), .div_start(div_start),
    .div_a(div_a), .div_b(div_b), .div_done(div_done), .div_quot(div_quot),
    .div_rem(div_rem), .div_zero(div_zero), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic
  function automatic logic [63:0] mul_ref(input logic [31:0] a, input logic [31:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return p;
  endfunction

  // Returns {rem, quot}; a zero divisor yields all-ones quotient and the dividend as remainder.
  function automatic logic [63:0] div_ref(input logic [31:0] a, input logic [31:0] b);
    longint q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    q = longint'($signed(a)) / longint'($signed(b));
    r = longint'($signed(a)) % longint'($signed(b));
    return {r[31:0], q[31:0]};
  endfunction

  // Behavioural units: per-start config is queued by stimulus
  bit mul_hang_q[$];
  int div_lat_q[$];
  bit div_hang_q[$];
  int mcnt, dcnt;
  logic mul_done_m, mul_done_force;
  assign mul_done = mul_done_m | mul_done_force;

  always @(posedge clk) begin
    if (reset) begin
      mcnt <= 0; mul_done_m <= 1'b0; mul_result <= '0;
    end else if (mul_start) begin
      mcnt       <= (mul_hang_q.size() != 0 && mul_hang_q.pop_front()) ? -1 : 33;
      mul_done_m <= 1'b0;
      mul_result <= mul_ref(mul_a, mul_b);
    end else if (mcnt > 0) begin
      mcnt <= mcnt - 1;
      if (mcnt == 1) mul_done_m <= 1'b1;
    end
  end

  always @(posedge clk) begin
    if (reset) begin
      dcnt <= 0; div_done <= 1'b0; div_quot <= '0; div_rem <= '0;
    end else if (div_start) begin
      int lat;
      bit hng;
      lat = (div_lat_q.size() != 0) ? div_lat_q.pop_front() : 33;
      hng = (div_hang_q.size() != 0) ? div_hang_q.pop_front() : 1'b0;
      dcnt     <= hng ? -1 : lat;
      div_done <= 1'b0;
      {div_rem, div_quot} <= div_ref(div_a, div_b);
    end else if (dcnt > 0) begin
      dcnt <= dcnt - 1;
      if (dcnt == 1) div_done <= 1'b1;
    end
  end

  // Scoreboard
  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        terr;
    int          cycles;
    int          ms;
    int          ds;
    int          dz;
  } exp_t;
  exp_t sb[$];

  logic [31:0] m_hi, m_lo;
  logic        m_terr;

`ifdef MULDIV_DIVZERO_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  // Monitor: values captured at one negedge describe what the following posedge sampled.
  int busy_cnt = 0, ms_cnt = 0, ds_cnt = 0, dz_cnt = 0;
  logic p_rst = 1'b1, p_acc = 1'b0, p_busy = 1'b0;
  logic [1:0] p_code = 2'b00;
  logic [31:0] p_b = '0;

  task automatic pop_check(input string tag);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s_unexpected_completion: got completion expected none at %0t", tag, $time);
    end else begin
      e = sb.pop_front();
      chk({tag, "_hi"}, 64'(hi), 64'(e.hi));
      chk({tag, "_lo"}, 64'(lo), 64'(e.lo));
      chk({tag, "_timeout_err"}, 64'(timeout_err), 64'(e.terr));
      chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(e.cycles));
      chk({tag, "_mul_start_pulses"}, 64'(ms_cnt), 64'(e.ms));
      chk({tag, "_div_start_pulses"}, 64'(ds_cnt), 64'(e.ds));
      chk({tag, "_div_zero_pulses"}, 64'(dz_cnt), 64'(e.dz));
    end
    busy_cnt = 0; ms_cnt = 0; ds_cnt = 0; dz_cnt = 0;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (p_rst) begin
        busy_cnt = 0; ms_cnt = 0; ds_cnt = 0; dz_cnt = 0;
      end else begin
        if (busy) busy_cnt++;
        if (mul_start) begin
          ms_cnt++;
          chk("mul_start_cycle", 64'(busy_cnt), 64'd1);
        end
        if (div_start) ds_cnt++;
        if (div_zero) dz_cnt++;
        chk("ready_vs_busy", 64'(op_ready), 64'(!busy));
        if (p_acc && p_code[1]) pop_check("move");
        else if (TRAP && p_acc && p_code == 2'b01 && p_b == 32'd0) pop_check("divzero_trap");
        if (p_busy && !busy) pop_check("muldiv");
      end
      p_rst  = reset;
      p_acc  = op_valid && op_ready;
      p_code = op_code;
      p_b    = op_b;
      p_busy = busy;
    end
  end

  // Stimulus
  task automatic issue(input logic [1:0] c, input logic [31:0] a, input logic [31:0] b);
    bit got;
    int n;
    got = 0; n = 0;
    op_valid = 1'b1; op_code = c; op_a = a; op_b = b;
    while (!got && n < 300) begin
      @(negedge clk);
      if (op_ready) got = 1;
      n++;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL accept_wait: got no op_ready expected op_ready within 300 cycles");
    end
    @(posedge clk); #2;
    op_valid = 1'b0;
  endtask

  task automatic do_op(input logic [1:0] c, input logic [31:0] a, input logic [31:0] b,
                       input int lat, input bit hang);
    exp_t e;
    logic [63:0] r;
    e.cycles = 0; e.ms = 0; e.ds = 0; e.dz = 0;
    case (c)
      2'b00: begin
        e.ms = 1;
        mul_hang_q.push_back(hang);
        if (hang) begin m_terr = 1'b1; e.cycles = TMO + 1; end
        else begin r = mul_ref(a, b); m_hi = r[63:32]; m_lo = r[31:0]; e.cycles = 35; end
      end
      2'b01: begin
        if (TRAP && b == 32'd0) begin
          e.dz = 1;
        end else begin
          e.ds = 1;
          div_lat_q.push_back(lat);
          div_hang_q.push_back(hang);
          if (hang) begin m_terr = 1'b1; e.cycles = TMO + 1; end
          else begin r = div_ref(a, b); m_hi = r[63:32]; m_lo = r[31:0]; e.cycles = lat + 2; end
        end
      end
      2'b10: m_hi = a;
      default: m_lo = a;
    endcase
    e.hi = m_hi; e.lo = m_lo; e.terr = m_terr;
    sb.push_back(e);
    issue(c, a, b);
  endtask

  task automatic drain;
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0 || busy) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0 within 500 cycles", sb.size());
    end
    @(posedge clk); #2;
  endtask

  initial begin
    reset = 1'b1; op_valid = 1'b0; op_code = 2'b00; op_a = '0; op_b = '0;
    mul_done_force = 1'b0;
    m_hi = '0; m_lo = '0; m_terr = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_op_ready", 64'(op_ready), 64'd1);
    chk("rst_starts", 64'({mul_start, div_start, div_zero, timeout_err}), 64'd0);
    chk("rst_operands", {mul_a, div_b}, 64'd0);
    @(posedge clk); #2;

    // Directed cases from the plan
    do_op(2'b00, 32'd7, 32'hFFFF_FFFD, 0, 1'b0);
    drain();
    chk("mult_const_lo", 64'(lo), 64'hFFFF_FFEB);
    chk("mult_const_hi", 64'(hi), 64'hFFFF_FFFF);
    chk("mult_operands_held", {mul_a, mul_b}, {32'd7, 32'hFFFF_FFFD});
    do_op(2'b01, 32'd100, 32'd7, 33, 1'b0);
    drain();
    chk("div_const_lo", 64'(lo), 64'd14);
    chk("div_const_hi", 64'(hi), 64'd2);
    do_op(2'b10, 32'hDEAD_BEEF, 32'd0, 0, 1'b0);
    do_op(2'b11, 32'h1234_5678, 32'd0, 0, 1'b0);
    drain();
    do_op(2'b01, 32'd5, 32'd0, 33, 1'b0);
    drain();

    // Randomized mix; the requester holds each op until accepted.
    for (int i = 0; i < 40; i++) begin
      logic [1:0] c;
      logic [31:0] a, b;
      c = 2'($urandom_range(0, 3));
      a = $urandom();
      b = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom();
      if ($urandom_range(0, 3) == 0) a = 32'($signed(-$urandom_range(0, 9)));
      do_op(c, a, b, $urandom_range(1, 40), 1'b0);
    end
    drain();

    // Watchdog: units never answer.
    do_op(2'b00, 32'd3, 32'd4, 0, 1'b1);
    drain();
    do_op(2'b01, 32'd9, 32'd2, 20, 1'b1);
    drain();
    for (int i = 0; i < 6; i++)
      do_op(2'($urandom_range(0, 3)), $urandom(), $urandom_range(1, 1000), $urandom_range(1, 10), 1'b0);
    drain();

    // Reset 10 cycles into M_WAIT, then a late done must be ignored.
    do_op(2'b00, 32'd11, 32'd13, 0, 1'b0);
    repeat (11) @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk); #2;
    reset = 1'b0;
    sb.delete();
    m_hi = '0; m_lo = '0; m_terr = 1'b0;
    @(negedge clk);
    chk("midwait_rst_hi", 64'(hi), 64'd0);
    chk("midwait_rst_lo", 64'(lo), 64'd0);
    chk("midwait_rst_busy", 64'(busy), 64'd0);
    chk("midwait_rst_op_ready", 64'(op_ready), 64'd1);
    chk("midwait_rst_timeout_err", 64'(timeout_err), 64'd0);
    @(posedge clk); #2;
    mul_done_force = 1'b1;
    repeat (3) @(posedge clk);
    #2 mul_done_force = 1'b0;
    @(negedge clk);
    chk("late_done_hi", 64'(hi), 64'd0);
    chk("late_done_lo", 64'(lo), 64'd0);
    chk("late_done_busy", 64'(busy), 64'd0);
    @(posedge clk); #2;
    do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
    drain();

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
